// File: rtl/logic_pkg.sv
// Shared opcode and FSM encodings for the shared bitwise logic unit arbiter.
package logic_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational 32-bit bitwise logic unit; the reserved opcode yields zero and flags err.
module logic_op_unit
  import logic_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_arbiter.sv
// Round-robin arbiter sharing one logic unit among NREQ requesters, with a single
// registered response channel tagged by requester id.
module logic_arbiter
  import logic_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic [31:0]       done_cnt,
  output state_t            dbg_state
);

  // Handshake: a transfer happens on a cycle where valid and ready are both high;
  // valid-side payload must stay stable until that cycle.
  state_t          state_q, state_d;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  start;
  logic [IDW-1:0]  off;
  logic [IDW-1:0]  grant_idx;
  logic [2*NREQ-1:0] dbl_valid;
  logic [NREQ-1:0] rot_valid;
  logic            found;
  logic            can_issue;
  logic            fire;
  logic [2:0]      sel_op;
  logic [31:0]     sel_a, sel_b;
  logic [31:0]     unit_y;
  logic            unit_err;
  logic [31:0]     done_cnt_q;

  assign can_issue = resetn & ((state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_ready));

  // Rotate so the search starts at last_grant+1, find first, then rotate back.
  always_comb begin
    start     = IDW'(last_grant + 1'b1);
    dbl_valid = {req_valid, req_valid};
    rot_valid = NREQ'(dbl_valid >> start);
    found     = 1'b0;
    off       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot_valid[i]) begin
        found = 1'b1;
        off   = IDW'(i);
      end
    end
    grant_idx = start + off;
    req_ready = (can_issue && found) ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

  assign fire   = |req_ready;
  assign sel_op = req_op[int'(grant_idx)*3 +: 3];
  assign sel_a  = req_a[int'(grant_idx)*32 +: 32];
  assign sel_b  = req_b[int'(grant_idx)*32 +: 32];

  logic_op_unit u_op (
    .op  (sel_op),
    .a   (sel_a),
    .b   (sel_b),
    .y   (unit_y),
    .err (unit_err)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fire) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = fire ? ST_RESP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      last_grant <= IDW'(NREQ - 1);
      done_cnt_q <= '0;
    end else begin
      if (fire) begin
        rsp_id     <= grant_idx;
        rsp_data   <= unit_y;
        rsp_err    <= unit_err;
        last_grant <= grant_idx;
      end
      if (rsp_valid && rsp_ready) done_cnt_q <= done_cnt_q + 32'd1;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign done_cnt  = done_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_logic_arbiter.sv
// Randomized and directed checks of logic_arbiter against a behavioural model.
module tb_logic_arbiter;
  import logic_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk;
  logic               resetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [3*NREQ-1:0]  req_op;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;
  logic               rsp_err;
  logic [31:0]        done_cnt;
  state_t             dbg_state;

  int total = 0;
  int bad   = 0;

  // Model state
  logic        m_valid;
  int          m_id;
  logic [31:0] m_data;
  logic        m_err;
  logic [31:0] m_cnt;
  int          m_last;
  int          last_g;

  logic [31:0] exp_tab [8];

  logic_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .done_cnt  (done_cnt),
    .dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, ~a};
      3'd3: return {1'b0, ~(a & b)};
      3'd4: return {1'b0, ~(a | b)};
      3'd5: return {1'b0, a ^ b};
      3'd6: return {1'b0, ~(a ^ b)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // First valid requester after the last grant, or -1 if nothing may issue.
  function automatic int model_grant();
    int idx;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (m_last + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_id = 0; m_data = '0; m_err = 1'b0; m_cnt = '0; m_last = NREQ - 1;
  endtask

  task automatic check_rsp();
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_err", 32'(rsp_err), 32'(m_err));
    chk("done_cnt", done_cnt, m_cnt);
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[i*3 +: 3]  = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  // Called right after a negedge with inputs applied; returns at the next negedge.
  task automatic tick();
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [32:0] r;
    #1;
    g = model_grant();
    exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (m_valid && rsp_ready) m_cnt = m_cnt + 32'd1;
    if (g >= 0) begin
      r = ref_op(req_op[g*3 +: 3], req_a[g*32 +: 32], req_b[g*32 +: 32]);
      m_valid = 1'b1; m_id = g; m_err = r[32]; m_data = r[31:0]; m_last = g;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    last_g = g;
    @(negedge clk);
    check_rsp();
  endtask

  // Refresh operands of the granted or idle requesters; waiting ones keep theirs.
  task automatic randomize_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (i == last_g || !req_valid[i]) begin
        set_req(i, 3'($urandom_range(0, 7)), $urandom, $urandom);
        req_valid[i] = ($urandom_range(0, 3) != 0);
      end else if ($urandom_range(0, 9) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] held_data;
    exp_tab[0] = 32'h02040608; exp_tab[1] = 32'h1F3F5F7F; exp_tab[2] = 32'hEDCBA987;
    exp_tab[3] = 32'hFDFBF9F7; exp_tab[4] = 32'hE0C0A080; exp_tab[5] = 32'h1D3B5977;
    exp_tab[6] = 32'hE2C4A688; exp_tab[7] = 32'h00000000;
    last_g = -1;

    // Reset: all valid, no grant, outputs cleared
    resetn = 1'b0; rsp_ready = 1'b0; req_valid = '1;
    req_op = '0; req_a = '0; req_b = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    check_rsp();
    resetn = 1'b1; req_valid = '0;
    @(negedge clk);

    // Single request from requester 2
    set_req(2, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00);
    req_valid = 4'b0100; rsp_ready = 1'b1;
    tick();
    chk("single_id", 32'(rsp_id), 32'd2);
    chk("single_data", rsp_data, 32'hF000F000);
    req_valid = '0;
    tick();

    // Every opcode on requester 0, back-to-back
    for (int op = 0; op < 8; op++) begin
      set_req(0, 3'(op), 32'h12345678, 32'h0F0F0F0F);
      req_valid = 4'b0001;
      tick();
      chk("op_table_data", rsp_data, exp_tab[op]);
      chk("op_table_err", 32'(rsp_err), (op == 7) ? 32'd1 : 32'd0);
    end
    req_valid = '0;
    tick();

    // All requesters continuously valid: strictly cyclic grants
    for (int i = 0; i < NREQ; i++) set_req(i, 3'($urandom_range(0, 6)), $urandom, $urandom);
    req_valid = '1;
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("cyclic_id", 32'(rsp_id), 32'((n + 1) % NREQ));
      set_req(last_g, 3'($urandom_range(0, 6)), $urandom, $urandom);
    end

    // Backpressure for 5 cycles, then grant in the release cycle
    rsp_ready = 1'b0;
    held_data = rsp_data;
    repeat (5) begin
      tick();
      chk("bp_hold", rsp_data, held_data);
    end
    rsp_ready = 1'b1;
    tick();

    // Random traffic with random backpressure
    for (int n = 0; n < 300; n++) begin
      randomize_reqs();
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // done_cnt wrap
    req_valid = 4'b0010; rsp_ready = 1'b1;
    tick();
    req_valid = '0; rsp_ready = 1'b0;
    tick();
    force dut.done_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.done_cnt_q;
    m_cnt = 32'hFFFFFFFF;
    #1;
    chk("wrap_pre", done_cnt, 32'hFFFFFFFF);
    @(negedge clk);
    rsp_ready = 1'b1;
    tick();
    chk("wrap_zero", done_cnt, 32'd0);

    // Reset pulsed mid-response
    req_valid = 4'b0100; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req_valid = '0;
    tick();
    #1 resetn = 1'b0;
    model_reset();
    #1;
    check_rsp();
    #1 resetn = 1'b1;
    req_valid = 4'b1010; rsp_ready = 1'b1;
    tick();
    chk("post_rst_id", 32'(rsp_id), 32'd1);
    req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_arbiter.md
# logic_arbiter

Shares one 32-bit bitwise logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) between NREQ requesters. Arbitrates round-robin, registers the selected operation's result, and returns it on a single response channel tagged with the requester ID. It sits between the core's issue ports and the logic execution resource, with one operation in flight at a time and back-to-back issue.

## Interface
- NREQ, 4: number of requesters; power of two, 2..8.
- IDW, $clog2(NREQ): requester ID width.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_op  in  3*NREQ  opcode of requester i in bits [3i+2:3i].
- req_a  in  32*NREQ  operand A of requester i in bits [32i+31:32i].
- req_b  in  32*NREQ  operand B, same packing.
- rsp_valid  out  1  result held and valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  requester that issued the result.
- rsp_data  out  32  result.
- rsp_err  out  1  opcode was reserved (7).
- done_cnt  out  32  count of accepted responses; wraps.

## Operation
- Opcodes: 0 AND, 1 OR, 2 NOT A (B ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR. Opcode 7 is reserved: rsp_data=0 and rsp_err=1.
- FSM states:
  - IDLE (rsp_valid=0).
  - RESP (rsp_valid=1, holding rsp_id, rsp_data, rsp_err).
- can_issue = (state==IDLE) | (state==RESP & rsp_ready).
- Grant:
  - When can_issue is set and any req_valid is set, exactly one req_ready bit rises. It goes to the first valid requester, searching upward and wrapping, starting at last_grant+1 mod NREQ.
  - Otherwise req_ready=0.
- A request fires on req_valid[i] & req_ready[i]. On the next clock edge:
  - capture rsp_id=i and rsp_data=f(op,a,b);
  - set rsp_err;
  - set last_grant=i;
  - go to RESP.
- RESP, rsp_ready=1, no new fire: go to IDLE; rsp_data/rsp_id keep their values.
- RESP, rsp_ready=1, new fire in the same cycle: stay in RESP with the new result (back-to-back, one op per cycle).
- RESP, rsp_ready=0: hold all response outputs stable; req_ready=0.
- done_cnt increments by 1 on every rsp_valid & rsp_ready; 0xFFFFFFFF wraps to 0.
- Requesters must hold req_op/a/b stable while req_valid is high and not yet granted.
- A requester dropping req_valid before it is granted is legal. It loses its turn; the pointer is unchanged.

## Timing
- Reset (resetn=0, asynchronous): state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, done_cnt=0, last_grant=NREQ-1 (requester 0 has first priority). req_ready=0 while in reset.
- req_ready is combinational from req_valid, state, rsp_ready and last_grant. No combinational path from req_a/req_b to any output.
- Latency: the fire edge presents the result; rsp_valid is high the cycle after the grant.
- Throughput: 1 op/cycle when rsp_ready is held at 1.
- Fairness: with all NREQ requesters continuously valid, the grant sequence is strictly cyclic; no requester waits more than NREQ-1 grants.
- Reset asserted mid-RESP: the response is discarded without a handshake and done_cnt is cleared.

## Structure
- Package logic_pkg:
  - opcode localparams (OP_AND..OP_XNOR, OP_RSV=3'd7);
  - FSM state encoding (ST_IDLE, ST_RESP).
- Sub-module logic_op_unit (combinational): op[2:0], a, b -> y[31:0], err. Instantiated once after the operand mux.
- Top-level holds:
  - round-robin grant logic (rotate, find-first, rotate back);
  - operand/op mux indexed by the grant;
  - FSM, response registers, done_cnt.

## Test plan
- Reset then single request: req 2 valid, op=0, a=0xF0F0F0F0, b=0xFF00FF00. Required: req_ready=4'b0100 in that cycle; next cycle rsp_valid=1, rsp_id=2, rsp_data=0xF000F000, rsp_err=0.
- All 7 opcodes + reserved on req 0 with a=0x12345678, b=0x0F0F0F0F.
  - Required results: AND 0x02040608, OR 0x1F3F5F7F, NOT 0xEDCBA987, NAND 0xFDFBF9F7, NOR 0xE0C0A080, XOR 0x1D3B5977, XNOR 0xE2C4A688.
  - op 7 gives rsp_data 0, rsp_err=1.
- All 4 requesters valid continuously, rsp_ready=1. Required: rsp_id sequence 0,1,2,3,0,1…, one response per cycle; done_cnt=8 after 8 responses.
- Backpressure: rsp_ready=0 for 5 cycles during RESP. Required: rsp_* stable, req_ready=0 throughout. After rsp_ready=1, the next grant is issued in that same cycle.
- done_cnt wrap: after 2^32-1 accepted responses (force-initialised in the bench), one more response gives done_cnt=0.
- resetn pulsed low mid-RESP: outputs go to reset values immediately. The first grant after release goes to the lowest-numbered valid requester.
